// File: rtl/pc_queue_if.sv
// Fetch-side bundle for pc_queue: queue controls from the pipeline and the
// registered address queue and interruption copies driven back to it.
interface pc_queue_if #(
  parameter int WIDTH = 32
);
  logic             LE;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             trap;
  logic             rfi;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] nPC;
  logic [WIDTH-1:0] link;
  logic             in_delay_slot;
  logic [WIDTH-1:0] saved_PC;
  logic [WIDTH-1:0] saved_nPC;

  modport master (
    output LE, branch_taken, branch_target, trap, rfi,
    input  PC, nPC, link, in_delay_slot, saved_PC, saved_nPC
  );

  modport slave (
    input  LE, branch_taken, branch_target, trap, rfi,
    output PC, nPC, link, in_delay_slot, saved_PC, saved_nPC
  );
endinterface

// File: rtl/pc_queue.sv
// Two-entry instruction-address queue (PC / nPC) with one branch delay slot
// and trap / return-from-interrupt capture and restore of the whole queue.
module pc_queue #(
  parameter int                   WIDTH    = 32,
  parameter int                   STEP     = 4,
  parameter logic [WIDTH-1:0]     RESET_PC = '0,
  parameter logic [WIDTH-1:0]     TRAP_VEC = 32'h0000_0100
) (
  input  logic      clk,
  input  logic      reset,
  pc_queue_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    DELAY,
    TRAPPED
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LINK_OFS   = WIDTH'(2 * STEP);
  // STEP is a power of two, so STEP-1 covers exactly the sub-instruction bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] saved_pc_q, saved_pc_d;
  logic [WIDTH-1:0] saved_npc_q, saved_npc_d;
  logic [WIDTH-1:0] target_aligned;

  assign target_aligned = bus.branch_target & ALIGN_MASK;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    saved_pc_d  = saved_pc_q;
    saved_npc_d = saved_npc_q;

    if (bus.trap) begin
      saved_pc_d  = pc_q;
      saved_npc_d = npc_q;
      pc_d        = TRAP_VEC;
      npc_d       = TRAP_VEC + STEP_W;
      state_d     = TRAPPED;
    end else if (bus.rfi) begin
      pc_d    = saved_pc_q;
      npc_d   = saved_npc_q;
      state_d = RUN;
    end else if (bus.LE) begin
      // The queue shifts forward; a taken branch lands behind the delay slot.
      pc_d    = npc_q;
      npc_d   = bus.branch_taken ? target_aligned : npc_q + STEP_W;
      state_d = bus.branch_taken ? DELAY : RUN;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC + STEP_W;
      saved_pc_q  <= '0;
      saved_npc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      saved_pc_q  <= saved_pc_d;
      saved_npc_q <= saved_npc_d;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.nPC           = npc_q;
  assign bus.link          = pc_q + LINK_OFS;
  assign bus.in_delay_slot = (state_q == DELAY);
  assign bus.saved_PC      = saved_pc_q;
  assign bus.saved_nPC     = saved_npc_q;

endmodule

// File: tb/tb_pc_queue.sv
// Self-checking bench for pc_queue: directed walk of the address queue plus
// randomized traffic compared every cycle against a queue-based model.
module tb_pc_queue;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] STEP     = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] TRAP_VEC = 32'h100;

  logic clk;
  logic reset;

  pc_queue_if #(.WIDTH(WIDTH)) bus ();

  pc_queue #(
    .WIDTH   (WIDTH),
    .STEP    (4),
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue is literally a two-entry list [front, back].
  logic [31:0] mq[$];
  logic        m_ds;
  logic [31:0] m_spc, m_snpc;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq = '{RESET_PC, RESET_PC + STEP};
      m_ds = 1'b0; m_spc = '0; m_snpc = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.trap) begin
        m_spc = mq[0]; m_snpc = mq[1];
        mq = '{TRAP_VEC, TRAP_VEC + STEP};
        m_ds = 1'b0;
      end else if (bus.rfi) begin
        mq = '{m_spc, m_snpc};
        m_ds = 1'b0;
      end else if (bus.LE) begin
        void'(mq.pop_front());
        mq.push_back(bus.branch_taken ? (bus.branch_target & ~(STEP - 1)) : mq[0] + STEP);
        m_ds = bus.branch_taken;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_PC",        bus.PC,                   mq[0]);
      check("model_nPC",       bus.nPC,                  mq[1]);
      check("model_link",      bus.link,                 mq[0] + 2 * STEP);
      check("model_delay",     {31'b0, bus.in_delay_slot}, {31'b0, m_ds});
      check("model_saved_PC",  bus.saved_PC,             m_spc);
      check("model_saved_nPC", bus.saved_nPC,            m_snpc);
    end
  end

  task automatic step(input logic rs, input logic le, input logic bt,
                      input logic [31:0] tgt, input logic tr, input logic rf);
    @(negedge clk);
    reset             = rs;
    bus.LE            = le;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.trap          = tr;
    bus.rfi           = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [31:0] pc,
                          input logic [31:0] npc, input logic ds);
    check({tag, "_PC"},  bus.PC,  pc);
    check({tag, "_nPC"}, bus.nPC, npc);
    check({tag, "_ds"},  {31'b0, bus.in_delay_slot}, {31'b0, ds});
  endtask

  task automatic expect_saved(input string tag, input logic [31:0] spc, input logic [31:0] snpc);
    check({tag, "_sPC"},  bus.saved_PC,  spc);
    check({tag, "_snPC"}, bus.saved_nPC, snpc);
  endtask

  initial begin
    reset = 1'b0; bus.LE = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_target = '0; bus.trap = 1'b0; bus.rfi = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    expect_q("rst", 32'h0, 32'h4, 0);
    expect_saved("rst", 32'h0, 32'h0);
    step(0, 1, 0, 0, 0, 0); expect_q("seq1", 32'h4, 32'h8, 0);
    step(0, 1, 0, 0, 0, 0); expect_q("seq2", 32'h8, 32'hC, 0);
    step(0, 1, 0, 0, 0, 0); expect_q("seq3", 32'hC, 32'h10, 0);
    check("link_at_C", bus.link, 32'h14);

    // Back to PC=8, then a taken branch to a misaligned target.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); expect_q("pre_br", 32'h8, 32'hC, 0);
    step(0, 1, 1, 32'h43, 0, 0); expect_q("br", 32'hC, 32'h40, 1);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), $urandom, 0, 0);
      expect_q("stall", 32'hC, 32'h40, 1);
    end

    step(0, 1, 1, 32'h500, 1, 0); expect_q("trap", 32'h100, 32'h104, 0);
    expect_saved("trap", 32'hC, 32'h40);
    step(0, 0, 1, 32'h600, 0, 1); expect_q("rfi", 32'hC, 32'h40, 0);
    expect_saved("rfi", 32'hC, 32'h40);
    step(0, 1, 0, 0, 0, 0); expect_q("post_rfi", 32'h40, 32'h44, 0);

    // Park the queue at the top of the address space, trap out, and return.
    step(0, 1, 1, 32'hFFFF_FFF8, 0, 0); expect_q("br_top", 32'h44, 32'hFFFF_FFF8, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); expect_saved("trap_top", 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0); expect_q("trapped_adv", 32'h104, 32'h108, 0);
    step(0, 0, 0, 0, 0, 1); expect_q("wrap0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0);
    step(0, 1, 0, 0, 0, 0); expect_q("wrap1", 32'hFFFF_FFFC, 32'h0, 0);
    check("link_wrap", bus.link, 32'h4);
    step(0, 1, 0, 0, 0, 0); expect_q("wrap2", 32'h0, 32'h4, 0);

    // Branch in a delay slot: second target follows one instruction after the first.
    step(0, 1, 1, 32'h200, 0, 0); expect_q("dbr1", 32'h4, 32'h200, 1);
    step(0, 1, 1, 32'h301, 0, 0); expect_q("dbr2", 32'h200, 32'h300, 1);
    step(0, 1, 0, 0, 0, 0);       expect_q("dbr3", 32'h300, 32'h304, 0);

    step(0, 1, 0, 0, 1, 1); expect_q("trap_rfi", 32'h100, 32'h104, 0);
    expect_saved("trap_rfi", 32'h300, 32'h304);

    step(0, 1, 1, 32'h80, 0, 0); expect_q("pre_rst", 32'h104, 32'h80, 1);
    step(1, 1, 1, 32'h90, 1, 1); expect_q("rst_all", 32'h0, 32'h4, 0);
    expect_saved("rst_all", 32'h0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 24) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_queue.md
# pc_queue

Parametrised instruction-address queue for the fetch stage: the successor to the single 8-bit program counter. It holds the front (PC) and back (nPC) of the address queue, so taken branches execute one delay slot. It also captures the queue into interruption registers on a trap and restores it on return-from-interrupt. It feeds the instruction memory address and the link/return path of the branch unit.

## Interface

Parameters:
- WIDTH, 32, address width in bits
- STEP, 4, sequential increment (bytes per instruction); must be a power of two
- RESET_PC, 0, PC value after reset
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap (truncated to WIDTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- LE  input  1  advance enable; 0 = stall, queue holds
- branch_taken  input  1  branch in the PC slot is taken this cycle (sampled only when LE=1)
- branch_target  input  WIDTH  target address for branch_taken
- trap  input  1  interruption request; one-cycle pulse
- rfi  input  1  return-from-interrupt; one-cycle pulse
- PC  output  WIDTH  front of queue: address being fetched (registered)
- nPC  output  WIDTH  back of queue: next address (registered)
- link  output  WIDTH  PC + 2*STEP, mod 2^WIDTH (combinational from PC)
- in_delay_slot  output  1  the instruction at PC is a taken-branch delay slot (registered)
- saved_PC  output  WIDTH  interruption copy of PC (registered)
- saved_nPC  output  WIDTH  interruption copy of nPC (registered)

## Operation

- Each cycle performs exactly one action. Priority is reset > trap > rfi > LE > hold.
- Reset:
  - PC=RESET_PC, nPC=RESET_PC+STEP, in_delay_slot=0.
  - saved_PC=0, saved_nPC=0.
- Trap:
  - saved_PC<=PC, saved_nPC<=nPC; the pre-edge values are captured.
  - PC<=TRAP_VEC, nPC<=TRAP_VEC+STEP, in_delay_slot<=0.
  - Taken regardless of LE. A branch_taken in the same cycle is discarded.
- rfi (no trap):
  - PC<=saved_PC, nPC<=saved_nPC. saved_* are unchanged.
  - in_delay_slot<=0.
  - Taken regardless of LE. branch_taken is discarded.
- Advance (LE=1, no trap, no rfi):
  - PC<=nPC.
  - nPC<=branch_target if branch_taken, else nPC+STEP.
  - in_delay_slot<=branch_taken.
- Hold (LE=0, no trap, no rfi): all registers keep their values. branch_taken is ignored, so the producer must hold it until LE=1.
- Branch target alignment: the low log2(STEP) bits of branch_target are forced to 0 before loading.
- Branch in a delay slot is legal. Queue semantics apply: the second target follows exactly one instruction from the first target.
- Arithmetic: all sums are WIDTH bits and wrap mod 2^WIDTH. No overflow flag.
- Internal control is a 3-state machine, RUN / DELAY / TRAPPED, visible through in_delay_slot:
  - RUN->DELAY on an advance with branch_taken.
  - DELAY->RUN on an advance without branch_taken; DELAY->DELAY on an advance with branch_taken.
  - Any state->TRAPPED on trap.
  - TRAPPED->RUN on the first advance, or on rfi.
  - Reset forces RUN.

## Timing

- Single clock domain, all registered outputs update on the rising edge.
- Latency is one cycle from any control input to the new PC/nPC.
- link follows PC combinationally in the same cycle.
- A redirect takes effect at nPC on edge N and reaches PC on edge N+1. This is the one-instruction delay slot.
- A trap or rfi redirects PC on the very next edge (no delay slot).
- Reset mid-stall, mid-delay-slot or in the same cycle as trap/rfi wins unconditionally.
- trap and rfi asserted together: trap wins, and saved_* are overwritten with the current queue.

## Test plan

Defaults for all scenarios: WIDTH=32, STEP=4, RESET_PC=0, TRAP_VEC=0x100.

- Reset, then LE=1 for 3 cycles -> (PC,nPC) = (0,4), (4,8), (8,C), (C,10); in_delay_slot stays 0; link=0x14 when PC=0xC.
- At PC=8, branch_taken=1 with target 0x43 -> next (C,40) with in_delay_slot=1; next (40,44) with in_delay_slot=0. The target's low 2 bits are dropped.
- LE=0 for 4 cycles with branch_taken toggling randomly -> PC/nPC/in_delay_slot unchanged throughout.
- trap at (PC,nPC)=(C,40), same cycle as branch_taken -> (100,104); saved_PC=C, saved_nPC=40. A later rfi -> (C,40), then an advance -> (40,44).
- Start at PC=0xFFFF_FFF8 via rfi, then LE=1 for 2 cycles -> nPC wraps: (FFFFFFF8,FFFFFFFC) -> (FFFFFFFC,0) -> (0,4).
- reset asserted during a delay slot, together with trap and rfi -> (0,4), in_delay_slot=0, saved_PC=saved_nPC=0.
